ps2_key_rx: RTL and testbench

- Receives raw PS/2 keyboard clock/data lines and decodes each scan-code frame.
- Produces the 11-bit toggle-handshake key-event word consumed by the core's keyboard handler: [10] toggle, [9] pressed, [8] extended, [7:0] code.
- Handles E0 (extended) and F0 (release) prefixes and filters line noise.
- Sits between the external PS/2 pins and the core's input-mapping logic, in the core clock domain (clk_25).

---
 rtl/ps2_pkg.sv | 33 +++
 rtl/ps2_line_sync.sv | 60 ++++++
 rtl/ps2_key_rx.sv | 158 +++++++++++++++
 tb/tb_ps2_key_rx.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_REL = 8'hF0;

    // Bytes that carry no key meaning: pause prefix, self-test, ack, echo, resend, errors.
    localparam int NUM_DISCARD = 7;
    localparam logic [NUM_DISCARD-1:0][7:0] DISCARD_LIST = {
        8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF
    };

    localparam int KEY_TOGGLE  = 10;
    localparam int KEY_PRESSED = 9;
    localparam int KEY_EXT     = 8;

    function automatic logic is_discard(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_DISCARD; i++) begin
            if (b == DISCARD_LIST[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchronizes the raw PS/2 lines, debounces the clock and flags its falling edges.
module ps2_line_sync #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic fall_strobe,
    output logic data_s
);
    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic          clk_meta_q, clk_sync_q;
    logic          data_meta_q, data_sync_q;
    logic          filt_q, filt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fall_q, fall_d;

    // Filtered clock follows the synchronized clock only after FILTER_LEN disagreeing samples.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        fall_d = 1'b0;
        if (clk_sync_q == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
            filt_d = clk_sync_q;
            cnt_d  = '0;
            fall_d = filt_q;   // old level 1 means this change is a fall
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Synchronizer and filter state; lines idle high so everything resets to 1.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
            filt_q      <= 1'b1;
            cnt_q       <= '0;
            fall_q      <= 1'b0;
        end else begin
            clk_meta_q  <= ps2_clk;
            clk_sync_q  <= clk_meta_q;
            data_meta_q <= ps2_data;
            data_sync_q <= data_meta_q;
            filt_q      <= filt_d;
            cnt_q       <= cnt_d;
            fall_q      <= fall_d;
        end
    end

    assign fall_strobe = fall_q;
    assign data_s      = data_sync_q;

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard frame receiver producing a toggle-handshake key-event word.
module ps2_key_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic        clk_i,
    input  logic        btnCpuReset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        parity_err,
    output logic        frame_err,
    output logic        busy
);
    localparam int TW = $clog2(TIMEOUT_CYC);

    logic fall;
    logic data_s;

    ps2_line_sync #(
        .FILTER_LEN (FILTER_LEN)
    ) u_line_sync (
        .clk_i       (clk_i),
        .rst_n       (btnCpuReset),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .fall_strobe (fall),
        .data_s      (data_s)
    );

    ps2_state_e    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          ext_q, ext_d;
    logic          rel_q, rel_d;
    logic [10:0]   key_q, key_d;
    logic          perr_q, perr_d;
    logic          ferr_q, ferr_d;
    logic          busy_q, busy_d;

    // Frame sequencing, stop/parity check, prefix tracking and event dispatch.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        ext_d     = ext_q;
        rel_d     = rel_q;
        key_d     = key_q;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        tmo_d     = (state_q == IDLE) ? '0 : tmo_q + 1'b1;
        if (fall) tmo_d = '0;

        case (state_q)
            IDLE: begin
                if (fall) begin
                    if (!data_s) begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            DATA: begin
                if (fall) begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
            end
            PARITY: begin
                if (fall) begin
                    par_d   = data_s;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_d = IDLE;
                    if (!data_s) begin
                        ferr_d = 1'b1;
                        ext_d  = 1'b0;
                        rel_d  = 1'b0;
                    end else if ((^{shift_q, par_q}) != 1'b1) begin
                        perr_d = 1'b1;
                        ext_d  = 1'b0;
                        rel_d  = 1'b0;
                    end else if (shift_q == PS2_EXT) begin
                        ext_d = 1'b1;
                    end else if (shift_q == PS2_REL) begin
                        rel_d = 1'b1;
                    end else if (is_discard(shift_q)) begin
                        ext_d = 1'b0;
                        rel_d = 1'b0;
                    end else begin
                        key_d[7:0]         = shift_q;
                        key_d[KEY_EXT]     = ext_q;
                        key_d[KEY_PRESSED] = ~rel_q;
                        key_d[KEY_TOGGLE]  = ~key_q[KEY_TOGGLE];
                        ext_d              = 1'b0;
                        rel_d              = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A fall on the terminal count wins; otherwise the stalled frame is dropped.
        if (state_q != IDLE && !fall && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            state_d = IDLE;
            ferr_d  = 1'b1;
            tmo_d   = '0;
        end

        busy_d = (state_d != IDLE);
    end

    // All receiver state and registered outputs.
    always_ff @(posedge clk_i or negedge btnCpuReset) begin
        if (!btnCpuReset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tmo_q     <= '0;
            ext_q     <= 1'b0;
            rel_q     <= 1'b0;
            key_q     <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tmo_q     <= tmo_d;
            ext_q     <= ext_d;
            rel_q     <= rel_d;
            key_q     <= key_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
        end
    end

    assign ps2_key    = key_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_ps2_key_rx.sv
// Directed bench for ps2_key_rx: frames, prefixes, errors, timeout, glitches, reset.
`timescale 1ns/1ps
module tb_ps2_key_rx;

    localparam int HALF = 20;   // PS/2 half bit period in clk_i cycles

    logic        clk_i = 1'b0;
    logic        btnCpuReset = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [10:0] ps2_key;
    logic        parity_err;
    logic        frame_err;
    logic        busy;

    int tests_run = 0;
    int tests_failed = 0;
    int perr_cnt = 0;
    int ferr_cnt = 0;
    int tog_cnt = 0;
    logic prev_tog = 1'b0;
    int lat;

    ps2_key_rx #(
        .FILTER_LEN  (8),
        .TIMEOUT_CYC (50000)
    ) dut (
        .clk_i       (clk_i),
        .btnCpuReset (btnCpuReset),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .ps2_key     (ps2_key),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #20 clk_i = ~clk_i;

    // Pulse and toggle counters sampled away from the active edge.
    always @(negedge clk_i) begin
        if (parity_err) perr_cnt++;
        if (frame_err) ferr_cnt++;
        if (ps2_key[10] !== prev_tog) tog_cnt++;
        prev_tog = ps2_key[10];
    end

    initial begin
        #(40 * 200000);
        $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
        $fatal(1);
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    // Full frame; lat = cycles from raw stop-bit fall to a ps2_key change (-1 if none).
    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                              output int lat_o);
        logic [10:0] key0;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        ps2_data = stop;
        wait_cyc(HALF);
        key0 = ps2_key;
        ps2_clk = 1'b0;
        lat_o = -1;
        for (int i = 1; i <= HALF; i++) begin
            wait_cyc(1);
            if (lat_o < 0 && ps2_key !== key0) lat_o = i;
        end
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(2 * HALF);
    endtask

    task automatic good(input logic [7:0] b);
        int l;
        send_frame(b, ~^b, 1'b1, l);
    endtask

    task automatic test_reset();
        btnCpuReset = 1'b0;
        wait_cyc(5);
        tests_run++;
        if (ps2_key !== 11'h000) begin tests_failed++; $display("FAIL reset_key: got %h, required 000", ps2_key); end
        tests_run++;
        if (parity_err !== 1'b0) begin tests_failed++; $display("FAIL reset_perr: got %b, required 0", parity_err); end
        tests_run++;
        if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL reset_ferr: got %b, required 0", frame_err); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b, required 0", busy); end
        btnCpuReset = 1'b1;
        wait_cyc(30);
        $display("[TB] reset: key=%h busy=%b", ps2_key, busy);
    endtask

    task automatic test_basic();
        int p0, f0;
        p0 = perr_cnt; f0 = ferr_cnt;
        send_frame(8'h1C, 1'b0, 1'b1, lat);
        tests_run++;
        if (ps2_key !== 11'h61C) begin tests_failed++; $display("FAIL basic_key: got %h, required 61C", ps2_key); end
        tests_run++;
        if (!(lat >= 10 && lat <= 13)) begin tests_failed++; $display("FAIL basic_latency: got %0d, required 10..13", lat); end
        tests_run++;
        if (perr_cnt - p0 != 0) begin tests_failed++; $display("FAIL basic_perr: got %0d pulses, required 0", perr_cnt - p0); end
        tests_run++;
        if (ferr_cnt - f0 != 0) begin tests_failed++; $display("FAIL basic_ferr: got %0d pulses, required 0", ferr_cnt - f0); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL basic_busy: got %b, required 0", busy); end
        $display("[TB] frame 1C: key=%h latency=%0d", ps2_key, lat);
    endtask

    task automatic test_prefix();
        int t0;
        t0 = tog_cnt;
        good(8'hE0);
        tests_run++;
        if (ps2_key !== 11'h61C) begin tests_failed++; $display("FAIL prefix_e0_noevent: got %h, required 61C", ps2_key); end
        good(8'hF0);
        tests_run++;
        if (ps2_key !== 11'h61C) begin tests_failed++; $display("FAIL prefix_f0_noevent: got %h, required 61C", ps2_key); end
        good(8'h6B);
        tests_run++;
        if (ps2_key !== 11'h16B) begin tests_failed++; $display("FAIL prefix_key: got %h, required 16B", ps2_key); end
        tests_run++;
        if (tog_cnt - t0 != 1) begin tests_failed++; $display("FAIL prefix_toggles: got %0d, required 1", tog_cnt - t0); end
        $display("[TB] frames E0 F0 6B: key=%h toggles=%0d", ps2_key, tog_cnt - t0);
    endtask

    task automatic test_parity();
        int p0, l;
        good(8'hF0);
        p0 = perr_cnt;
        send_frame(8'h29, 1'b1, 1'b1, l);
        tests_run++;
        if (perr_cnt - p0 != 1) begin tests_failed++; $display("FAIL parity_pulse: got %0d pulses, required 1", perr_cnt - p0); end
        tests_run++;
        if (ps2_key !== 11'h16B) begin tests_failed++; $display("FAIL parity_key_held: got %h, required 16B", ps2_key); end
        good(8'h29);
        tests_run++;
        if (ps2_key !== 11'h629) begin tests_failed++; $display("FAIL parity_rel_cleared: got %h, required 629", ps2_key); end
        $display("[TB] F0 + bad-parity 29 + 29: key=%h", ps2_key);
    endtask

    task automatic test_frame_err();
        int p0, f0, l;
        p0 = perr_cnt; f0 = ferr_cnt;
        send_frame(8'h1C, 1'b0, 1'b0, l);
        tests_run++;
        if (ferr_cnt - f0 != 1) begin tests_failed++; $display("FAIL stop_ferr: got %0d pulses, required 1", ferr_cnt - f0); end
        tests_run++;
        if (ps2_key !== 11'h629) begin tests_failed++; $display("FAIL stop_key_held: got %h, required 629", ps2_key); end
        f0 = ferr_cnt;
        send_frame(8'h1C, 1'b1, 1'b0, l);
        tests_run++;
        if (ferr_cnt - f0 != 1) begin tests_failed++; $display("FAIL both_ferr: got %0d pulses, required 1", ferr_cnt - f0); end
        tests_run++;
        if (perr_cnt - p0 != 0) begin tests_failed++; $display("FAIL both_no_perr: got %0d pulses, required 0", perr_cnt - p0); end
        f0 = ferr_cnt;
        send_bit(1'b1);
        wait_cyc(HALF);
        tests_run++;
        if (ferr_cnt - f0 != 1) begin tests_failed++; $display("FAIL start_ferr: got %0d pulses, required 1", ferr_cnt - f0); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL start_busy: got %b, required 0", busy); end
        $display("[TB] stop/start errors: key=%h", ps2_key);
    endtask

    task automatic test_timeout();
        int f0, err_at;
        logic busy_mid, busy_err;
        logic [7:0] b;
        b = 8'h55;
        f0 = ferr_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(b[i]);
        ps2_data = b[3];
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        err_at = -1; busy_mid = 1'b0; busy_err = 1'b1;
        for (int i = 1; i <= 50100; i++) begin
            wait_cyc(1);
            if (i == HALF) ps2_clk = 1'b1;
            if (i == 1000) busy_mid = busy;
            if (frame_err === 1'b1) begin
                err_at = i;
                busy_err = busy;
                break;
            end
        end
        ps2_data = 1'b1;
        tests_run++;
        if (busy_mid !== 1'b1) begin tests_failed++; $display("FAIL timeout_busy_mid: got %b, required 1", busy_mid); end
        tests_run++;
        if (!(err_at >= 49995 && err_at <= 50025)) begin tests_failed++; $display("FAIL timeout_cycle: got %0d, required 49995..50025", err_at); end
        tests_run++;
        if (busy_err !== 1'b0) begin tests_failed++; $display("FAIL timeout_busy_drop: got %b, required 0", busy_err); end
        wait_cyc(HALF);
        tests_run++;
        if (ferr_cnt - f0 != 1) begin tests_failed++; $display("FAIL timeout_pulses: got %0d, required 1", ferr_cnt - f0); end
        good(8'h14);
        tests_run++;
        if (ps2_key !== 11'h214) begin tests_failed++; $display("FAIL timeout_recover: got %h, required 214", ps2_key); end
        $display("[TB] timeout at %0d cycles, then 14: key=%h", err_at, ps2_key);
    endtask

    task automatic test_glitch();
        int p0, f0, t0;
        logic busy_seen;
        p0 = perr_cnt; f0 = ferr_cnt; t0 = tog_cnt;
        busy_seen = 1'b0;
        for (int g = 0; g < 4; g++) begin
            ps2_clk = 1'b0;
            wait_cyc(3);
            ps2_clk = 1'b1;
            for (int c = 0; c < 15; c++) begin
                wait_cyc(1);
                if (busy) busy_seen = 1'b1;
            end
        end
        tests_run++;
        if (busy_seen !== 1'b0) begin tests_failed++; $display("FAIL glitch_busy: got %b, required 0", busy_seen); end
        tests_run++;
        if (ferr_cnt - f0 != 0) begin tests_failed++; $display("FAIL glitch_ferr: got %0d pulses, required 0", ferr_cnt - f0); end
        good(8'hAA);
        tests_run++;
        if (ps2_key !== 11'h214) begin tests_failed++; $display("FAIL discard_key: got %h, required 214", ps2_key); end
        tests_run++;
        if ((perr_cnt - p0) + (ferr_cnt - f0) + (tog_cnt - t0) != 0) begin
            tests_failed++;
            $display("FAIL discard_quiet: got %0d events/errors, required 0", (perr_cnt - p0) + (ferr_cnt - f0) + (tog_cnt - t0));
        end
        $display("[TB] glitches + AA: key=%h", ps2_key);
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        b = 8'h16;
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(b[i]);
        ps2_data = b[5];
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        wait_cyc(12);
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL midreset_busy_before: got %b, required 1", busy); end
        btnCpuReset = 1'b0;
        #1;
        tests_run++;
        if (ps2_key !== 11'h000) begin tests_failed++; $display("FAIL midreset_key: got %h, required 000", ps2_key); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL midreset_busy: got %b, required 0", busy); end
        tests_run++;
        if ({parity_err, frame_err} !== 2'b00) begin tests_failed++; $display("FAIL midreset_errs: got %b, required 00", {parity_err, frame_err}); end
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(5);
        btnCpuReset = 1'b1;
        wait_cyc(40);
        good(8'h16);
        tests_run++;
        if (ps2_key !== 11'h616) begin tests_failed++; $display("FAIL midreset_recover: got %h, required 616", ps2_key); end
        $display("[TB] mid-frame reset, then 16: key=%h", ps2_key);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_prefix();
        test_parity();
        test_frame_err();
        test_timeout();
        test_glitch();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
